// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg -- shared types and constants for the instruction fetch stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_adder.sv
// ---------------------------------------------------------------------------
// adder -- adds the constant increment B to an N-bit operand, wrapping modulo 2^N
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module adder #(
  parameter int N = 32,
  parameter int B = 4
) (
  input  logic [N-1:0] a_i,
  output logic [N-1:0] y_o
);

  assign y_o = a_i + N'(B);

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- IF stage: drives instruction memory, feeds the IF/ID register
// through a one-entry skid buffer so no acked word is lost under stall. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter int             n        = 32,
  parameter logic [n-1:0]   RESET_PC = n'(DEFAULT_RESET_PC)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         redirect,
  input  logic [n-1:0] redirect_pc,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [n-1:0] imem_rdata,
  output logic         if_valid,
  output logic [n-1:0] if_instr,
  output logic [n-1:0] if_pc,
  output logic [n-1:0] if_pc_plus4
);

  state_e       state_q;
  logic [n-1:0] pc_q;
  logic [n-1:0] pc_plus4_d;
  logic         req_q;
  logic         if_valid_q;
  logic [n-1:0] if_instr_q;
  logic [n-1:0] if_pc_q;
  logic [n-1:0] if_pc4_q;
  logic [n-1:0] skid_instr_q;
  logic [n-1:0] skid_pc_q;
  logic [n-1:0] skid_pc4_q;
  logic         slot_free;
  logic         unused_rpc_bits;

  assign unused_rpc_bits = ^redirect_pc[1:0];
  assign slot_free       = !if_valid_q || !stall;

  adder #(
    .N (n),
    .B (INSTR_BYTES)
  ) u_pc_inc (
    .a_i (pc_q),
    .y_o (pc_plus4_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      if_pc4_q     <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_pc4_q   <= '0;
    end else if (redirect) begin
      // Redirect overrides everything: any ack this cycle and the skid entry are dropped.
      state_q    <= ST_FETCH;
      req_q      <= 1'b1;
      pc_q       <= {redirect_pc[n-1:2], 2'b00};
      if_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            pc_q <= pc_plus4_d;
            if (slot_free) begin
              if_valid_q <= 1'b1;
              if_instr_q <= imem_rdata;
              if_pc_q    <= pc_q;
              if_pc4_q   <= pc_plus4_d;
            end else begin
              skid_instr_q <= imem_rdata;
              skid_pc_q    <= pc_q;
              skid_pc4_q   <= pc_plus4_d;
              state_q      <= ST_HOLD;
              req_q        <= 1'b0;
            end
          end else if (!stall) begin
            if_valid_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            if_valid_q <= 1'b1;
            if_instr_q <= skid_instr_q;
            if_pc_q    <= skid_pc_q;
            if_pc4_q   <= skid_pc4_q;
            state_q    <= ST_FETCH;
            req_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc4_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit -- directed and randomized stimulus for fetch_unit with an
// in-order scoreboard of acked words. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_ack = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  item_t       sb[$];
  logic [31:0] exp_pc = RST_PC;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  assign imem_rdata = word(imem_addr);

  always #5 clk = ~clk;

  fetch_unit #(
    .n        (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard bookkeeping for the upcoming edge, then advance one cycle.
  task automatic tick();
    item_t it;
    check("imem_addr", imem_addr, exp_pc);
    if (if_valid && !stall && !redirect) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_underflow observed=empty expected=entry");
      end
      if (sb.size() > 0) begin
        it = sb.pop_front();
        check("sb_instr", if_instr, it.instr);
        check("sb_pc", if_pc, it.pc);
        check("sb_pc4", if_pc_plus4, it.pc4);
      end
    end
    if (redirect) begin
      sb.delete();
      exp_pc = {redirect_pc[31:2], 2'b00};
    end else if (imem_req && imem_ack) begin
      it.pc    = exp_pc;
      it.instr = word(exp_pc);
      it.pc4   = exp_pc + 32'd4;
      sb.push_back(it);
      exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_pc4", if_pc_plus4, 32'd0);
    check("rst_addr", imem_addr, RST_PC);

    // Release with continuous ack
    rst_n = 1'b1;
    imem_ack = 1'b1;
    tick();
    check("idle_req", {31'b0, imem_req}, 32'd1);
    check("idle_valid", {31'b0, if_valid}, 32'd0);
    tick();
    check("first_valid", {31'b0, if_valid}, 32'd1);
    check("first_pc", if_pc, 32'h0);
    check("first_pc4", if_pc_plus4, 32'h4);
    check("first_instr", if_instr, word(32'h0));
    check("addr_4", imem_addr, 32'h4);
    tick();
    check("addr_8", imem_addr, 32'h8);
    tick();
    check("addr_c", imem_addr, 32'hC);

    // Stall for three cycles while ack stays high
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_req", {31'b0, imem_req}, 32'd0);
      check("hold_valid", {31'b0, if_valid}, 32'd1);
      check("hold_pc", if_pc, 32'h8);
      check("hold_instr", if_instr, word(32'h8));
      check("hold_pc4", if_pc_plus4, 32'hC);
      check("hold_addr", imem_addr, 32'h10);
    end
    stall = 1'b0;
    tick();
    check("skid_pc", if_pc, 32'hC);
    check("skid_req", {31'b0, imem_req}, 32'd1);
    tick();
    check("after_skid_pc", if_pc, 32'h10);

    // Redirect to 8, then redirect from pc=8 to 0x103 with ack high
    redirect = 1'b1;
    redirect_pc = 32'h8;
    tick();
    redirect = 1'b0;
    check("rd8_valid", {31'b0, if_valid}, 32'd0);
    check("rd8_addr", imem_addr, 32'h8);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    check("rd_valid", {31'b0, if_valid}, 32'd0);
    check("rd_addr", imem_addr, 32'h100);
    tick();
    check("rd_pc", if_pc, 32'h100);
    check("rd_valid2", {31'b0, if_valid}, 32'd1);

    // Redirect together with stall
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();
    stall = 1'b0;
    redirect = 1'b0;
    check("rdst_valid", {31'b0, if_valid}, 32'd0);
    check("rdst_addr", imem_addr, 32'h200);

    // Address wrap
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    check("wrap_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", if_pc_plus4, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);
    tick();

    // Ack withheld for four cycles
    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("noack_req", {31'b0, imem_req}, 32'd1);
      check("noack_addr", imem_addr, 32'h4);
      check("noack_valid", {31'b0, if_valid}, 32'd0);
    end
    imem_ack = 1'b1;
    tick();
    check("ack_back_pc", if_pc, 32'h4);
    check("ack_back_valid", {31'b0, if_valid}, 32'd1);

    // Asynchronous reset pulse while in HOLD
    stall = 1'b1;
    tick();
    check("pre_rst_req", {31'b0, imem_req}, 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_req", {31'b0, imem_req}, 32'd0);
    check("arst_valid", {31'b0, if_valid}, 32'd0);
    check("arst_instr", if_instr, 32'd0);
    check("arst_pc", if_pc, 32'd0);
    check("arst_pc4", if_pc_plus4, 32'd0);
    check("arst_addr", imem_addr, RST_PC);
    sb.delete();
    exp_pc = RST_PC;
    stall = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("rel_req", {31'b0, imem_req}, 32'd1);
    tick();
    check("rel_pc", if_pc, RST_PC);
    check("rel_valid", {31'b0, if_valid}, 32'd1);

    // Randomized ack/stall/redirect traffic
    for (int i = 0; i < 80; i++) begin
      imem_ack    = ($urandom_range(0, 3) != 0);
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      tick();
    end
    redirect = 1'b0;
    stall    = 1'b0;
    imem_ack = 1'b1;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter n, default 32: data/address width in bits.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  decode cannot accept; the held if_* outputs shall stay unchanged.
REQ-006 redirect  input  1  branch/jump taken; the fetch stream shall restart at redirect_pc.
REQ-007 redirect_pc  input  n  new fetch address; bits [1:0] ignored.
REQ-008 imem_req  output  1  instruction fetch request.
REQ-009 imem_addr  output  n  fetch address; equals the internal pc.
REQ-010 imem_ack  input  1  imem_rdata is valid for imem_addr in this cycle.
REQ-011 imem_rdata  input  n  instruction word.
REQ-012 if_valid  output  1  IF/ID register holds a live instruction.
REQ-013 if_instr  output  n  fetched instruction.
REQ-014 if_pc  output  n  address of if_instr.
REQ-015 if_pc_plus4  output  n  if_pc + 4, the sequential next-PC for the next stage.

Function
REQ-016 FSM states: IDLE, FETCH, HOLD; IDLE shall last exactly one cycle after reset release, then go to FETCH.
REQ-017 imem_req shall be 1 only in FETCH; imem_addr = pc in all states.
REQ-018 Slot free condition: if_valid=0 or stall=0.
REQ-019 FETCH with imem_ack and slot free: load if_instr=imem_rdata, if_pc=pc, if_pc_plus4=pc+4, if_valid=1; set pc to pc+4; stay in FETCH. Throughput is one instruction per cycle when ack is continuous.
REQ-020 FETCH with imem_ack and slot full: capture rdata, pc and pc+4 into a one-entry skid buffer; set pc to pc+4; go to HOLD.
REQ-021 HOLD with stall=0: load the IF/ID register from the skid buffer with if_valid=1, then go to FETCH.
REQ-022 No ack and stall=0: if_valid shall become 0 (instruction consumed, bubble).
REQ-023 stall=1 and if_valid=1: all if_* outputs shall hold their values.
REQ-024 redirect=1, highest priority in any state: set pc to {redirect_pc[n-1:2],2'b00}; set if_valid to 0; discard the skid buffer; go to FETCH; drop any imem_ack in the same cycle.
REQ-025 redirect and stall asserted together: the redirect wins and if_valid shall become 0.
REQ-026 pc+4 shall wrap modulo 2^n; pc[1:0] shall always be 00.
REQ-027 Latency: an instruction acked in cycle t shall appear with if_valid=1 in cycle t+1 when the slot is free.

Reset
REQ-028 On rst_n=0, immediately and independent of clk: pc=RESET_PC, state=IDLE, imem_req=0, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, skid buffer cleared.
REQ-029 Reset asserted mid-fetch shall abandon the request; after release, fetching shall restart at RESET_PC.

Structure
REQ-030 Package fetch_pkg shall hold the state enum type, INSTR_BYTES=4 and the default RESET_PC.
REQ-031 pc+4 shall be computed by one instance of the existing adder module (n-bit, B=INSTR_BYTES); no other sub-modules.

Verification
REQ-032 Reset release, ack held at 1: imem_addr steps 0,4,8,C; if_valid first rises 2 cycles after release with if_pc=0, if_pc_plus4=4.
REQ-033 stall=1 for 3 cycles while ack=1: if_* stays frozen; exactly one word is skidded; imem_req drops in HOLD; after release, the sequence continues with no loss or duplicate.
REQ-034 redirect_pc=32'h0000_0103 at pc=8 with ack=1: the acked word is dropped; if_valid=0 next cycle; the next imem_addr is 32'h0000_0100.
REQ-035 pc=32'hFFFF_FFFC, acked: if_pc_plus4=0 and the next imem_addr is 0.
REQ-036 ack=0 for 4 cycles: imem_req stays 1 with a stable address; if_valid falls after the first consumed cycle.
REQ-037 rst_n pulsed low between clock edges during HOLD: outputs clear immediately; the next fetch is at RESET_PC.
